pwr_seq_ctrl: RTL and testbench

- Power-sequencing controller for the Segway; replaces the bare pwr_up decision with a sequenced state machine.
- Consumes UART command bytes ('G' go, 'S' stop), rider_off from the steer-enable logic, the overcurrent shutdown flag and a battery-low flag.
- Drives pwr_up to the balance controller and a ramped torque scale that the motor-drive path multiplies into duty, giving soft-start after authorization and after fault recovery.

---
 rtl/pwr_seq_ctrl.sv | 169 ++++++++++++++++
 tb/tb_pwr_seq_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwr_seq_ctrl.sv
// Power-sequencing controller: decodes UART go/stop bytes, gates pwr_up and
// soft-starts the torque scale after authorization and after fault recovery.
module pwr_seq_ctrl #(
    parameter int          SCALE_W    = 8,
    parameter int          STEP_CLKS  = 64,
    parameter int          FAULT_HOLD = 4096,
    parameter logic [7:0]  G_CMD      = 8'h47,
    parameter logic [7:0]  S_CMD      = 8'h53
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rx_rdy,
    input  logic [7:0]         rx_data,
    output logic               clr_rx_rdy,
    input  logic               rider_off,
    input  logic               ovr_i_shtdwn,
    input  logic               batt_low,
    output logic               pwr_up,
    output logic [SCALE_W-1:0] trq_scale,
    output logic               fault,
    output logic [2:0]         state_o
);

    typedef enum logic [2:0] {
        ST_OFF       = 3'd0,
        ST_RAMP      = 3'd1,
        ST_ON        = 3'd2,
        ST_STOP_PEND = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    localparam int STEP_W = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
    localparam int HOLD_W = $clog2(FAULT_HOLD + 1);
    localparam logic [STEP_W-1:0]  STEP_LAST  = STEP_W'(STEP_CLKS - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(FAULT_HOLD);
    localparam logic [SCALE_W-1:0] SCALE_FULL = '1;

    state_t             state_reg, state_next;
    logic [SCALE_W-1:0] scale_reg, scale_next;
    logic [STEP_W-1:0]  step_reg,  step_next;
    logic [HOLD_W-1:0]  hold_reg,  hold_next;
    logic               clr_reg;
    logic               pwr_reg;
    logic               fault_reg;

    logic               seen;
    logic               go_cmd;
    logic               stop_cmd;
    logic               hold_done;
    logic               step_wrap;
    logic [SCALE_W-1:0] scale_inc;

    // The byte under the clr_rx_rdy pulse is the one already decoded.
    assign seen      = rx_rdy && !clr_reg;
    assign go_cmd    = seen && (rx_data == G_CMD);
    assign stop_cmd  = seen && (rx_data == S_CMD);
    assign hold_done = (hold_reg == HOLD_MAX);
    assign step_wrap = (step_reg == STEP_LAST);
    assign scale_inc = (scale_reg == SCALE_FULL) ? SCALE_FULL : scale_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        scale_next = scale_reg;
        step_next  = step_reg;
        hold_next  = hold_reg;

        if (ovr_i_shtdwn || state_reg != ST_FAULT) begin
            hold_next = '0;
        end else if (!hold_done) begin
            hold_next = hold_reg + 1'b1;
        end

        if (ovr_i_shtdwn) begin
            state_next = ST_FAULT;
            scale_next = '0;
            step_next  = '0;
        end else begin
            case (state_reg)
                ST_OFF: begin
                    scale_next = '0;
                    if (go_cmd && !batt_low) begin
                        state_next = ST_RAMP;
                        step_next  = '0;
                    end
                end
                ST_RAMP: begin
                    if (stop_cmd) begin
                        step_next = '0;
                        if (rider_off) begin
                            state_next = ST_OFF;
                            scale_next = '0;
                        end else begin
                            state_next = ST_STOP_PEND;
                        end
                    end else if (step_wrap) begin
                        step_next  = '0;
                        scale_next = scale_inc;
                        if (scale_inc == SCALE_FULL) begin
                            state_next = ST_ON;
                        end
                    end else begin
                        step_next = step_reg + 1'b1;
                    end
                end
                ST_ON: begin
                    scale_next = SCALE_FULL;
                    if (stop_cmd) begin
                        if (rider_off) begin
                            state_next = ST_OFF;
                            scale_next = '0;
                        end else begin
                            state_next = ST_STOP_PEND;
                        end
                    end
                end
                ST_STOP_PEND: begin
                    // Ramp is frozen here; a go resumes from the held scale.
                    if (go_cmd) begin
                        step_next  = '0;
                        state_next = (scale_reg == SCALE_FULL) ? ST_ON : ST_RAMP;
                    end else if (rider_off) begin
                        state_next = ST_OFF;
                        scale_next = '0;
                    end
                end
                ST_FAULT: begin
                    scale_next = '0;
                    if (go_cmd && hold_done && !batt_low) begin
                        state_next = ST_RAMP;
                        step_next  = '0;
                    end
                end
                default: begin
                    state_next = ST_OFF;
                    scale_next = '0;
                    step_next  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_OFF;
            scale_reg <= '0;
            step_reg  <= '0;
            hold_reg  <= '0;
            clr_reg   <= 1'b0;
            pwr_reg   <= 1'b0;
            fault_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            scale_reg <= scale_next;
            step_reg  <= step_next;
            hold_reg  <= hold_next;
            clr_reg   <= seen;
            pwr_reg   <= (state_next == ST_RAMP) || (state_next == ST_ON) ||
                         (state_next == ST_STOP_PEND);
            fault_reg <= (state_next == ST_FAULT);
        end
    end

    assign clr_rx_rdy = clr_reg;
    assign pwr_up     = pwr_reg;
    assign trq_scale  = scale_reg;
    assign fault      = fault_reg;
    assign state_o    = state_reg;

endmodule

// File: tb/tb_pwr_seq_ctrl.sv
// Directed bench for pwr_seq_ctrl: a vector table for single-cycle decode
// behaviour plus hand-timed sequences for ramp, stop-pending and fault hold.
module tb_pwr_seq_ctrl;

    localparam logic [7:0] G = 8'h47;
    localparam logic [7:0] S = 8'h53;
    localparam logic [7:0] A = 8'h41;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       clr_rx_rdy;
    logic       rider_off = 1'b0;
    logic       ovr_i_shtdwn = 1'b0;
    logic       batt_low = 1'b0;
    logic       pwr_up;
    logic [7:0] trq_scale;
    logic       fault;
    logic [2:0] state_o;

    int tests_run = 0;
    int fails = 0;

    typedef struct {
        logic       rdy;
        logic [7:0] data;
        logic       rider;
        logic       ovr;
        logic       batt;
        int         st;
        int         pwr;
        int         sc;
        int         flt;
        int         clr;
    } vec_t;

    vec_t vecs[10];

    pwr_seq_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_rdy       (rx_rdy),
        .rx_data      (rx_data),
        .clr_rx_rdy   (clr_rx_rdy),
        .rider_off    (rider_off),
        .ovr_i_shtdwn (ovr_i_shtdwn),
        .batt_low     (batt_low),
        .pwr_up       (pwr_up),
        .trq_scale    (trq_scale),
        .fault        (fault),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int st, input int pwr,
                              input int sc, input int flt);
        chk({tag, "_state"}, int'(state_o), st);
        chk({tag, "_pwr_up"}, int'(pwr_up), pwr);
        chk({tag, "_scale"}, int'(trq_scale), sc);
        chk({tag, "_fault"}, int'(fault), flt);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // rx_rdy is held through the clr cycle, as a real UART would.
    task automatic send_byte(input logic [7:0] b, input int exp_st, input string tag);
        rx_rdy  = 1'b1;
        rx_data = b;
        tick();
        chk({tag, "_state"}, int'(state_o), exp_st);
        chk({tag, "_clr"}, int'(clr_rx_rdy), 1);
        tick();
        chk({tag, "_clr_once"}, int'(clr_rx_rdy), 0);
        rx_rdy = 1'b0;
        $display("[TB] t=%0t %s byte=%02h state=%0d scale=%0d", $time, tag, b,
                 state_o, trq_scale);
    endtask

    initial begin
        //           rdy   data   rider  ovr   batt   st pwr sc flt clr
        vecs[0] = '{1'b1, G,     1'b0, 1'b0, 1'b1,  0, 0,  0, 0, 1};
        vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1,  0, 0,  0, 0, 0};
        vecs[2] = '{1'b1, A,     1'b0, 1'b0, 1'b0,  0, 0,  0, 0, 1};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0,  0, 0,  0, 0, 0};
        vecs[4] = '{1'b1, S,     1'b0, 1'b0, 1'b0,  0, 0,  0, 0, 1};
        vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0,  0, 0,  0, 0, 0};
        vecs[6] = '{1'b1, G,     1'b0, 1'b1, 1'b0,  4, 0,  0, 1, 1};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0,  4, 0,  0, 1, 0};
        vecs[8] = '{1'b1, G,     1'b0, 1'b0, 1'b0,  4, 0,  0, 1, 1};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0,  4, 0,  0, 1, 0};

        // Reset state
        #23;
        expect_out("rst", 0, 0, 0, 0);
        chk("rst_clr", int'(clr_rx_rdy), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        tick();
        expect_out("post_rst", 0, 0, 0, 0);

        // Authorization and full ramp: +1 every 64 clocks from RAMP entry
        send_byte(G, 1, "t1_go");
        expect_out("t1_ramp", 1, 1, 0, 0);
        ticks(62);
        chk("t1_scale_k63", int'(trq_scale), 0);
        tick();
        chk("t1_scale_k64", int'(trq_scale), 1);
        ticks(16255);
        expect_out("t1_k16319", 1, 1, 254, 0);
        tick();
        expect_out("t1_on", 2, 1, 255, 0);

        // Overcurrent from ON and fault hold timing
        ovr_i_shtdwn = 1'b1;
        tick();
        ovr_i_shtdwn = 1'b0;
        expect_out("t4_fault", 4, 0, 0, 1);
        ticks(1998);
        send_byte(G, 4, "t4_g2000");
        expect_out("t4_still", 4, 0, 0, 1);
        ticks(999);
        ovr_i_shtdwn = 1'b1;
        tick();
        ovr_i_shtdwn = 1'b0;
        expect_out("t4_repulse", 4, 0, 0, 1);
        ticks(3999);
        send_byte(G, 4, "t4_g4000");
        ticks(94);
        send_byte(G, 4, "t4_g_hold4095");
        send_byte(G, 1, "t4_g_sat");
        expect_out("t4_ramp", 1, 1, 0, 0);

        // Mid-ramp stop, long hold, resume
        ticks(4094);
        chk("t3_scale_3f", int'(trq_scale), 8'h3F);
        tick();
        chk("t3_scale_40", int'(trq_scale), 8'h40);
        send_byte(S, 3, "t3_stop");
        expect_out("t3_hold", 3, 1, 8'h40, 0);
        ticks(10000);
        expect_out("t3_held", 3, 1, 8'h40, 0);
        send_byte(G, 1, "t3_resume");
        ticks(62);
        chk("t3_scale_k63", int'(trq_scale), 8'h40);
        tick();
        chk("t3_scale_k64", int'(trq_scale), 8'h41);
        ticks(12159);
        expect_out("t3_k12223", 1, 1, 254, 0);
        tick();
        expect_out("t3_on", 2, 1, 255, 0);

        // ON corner cases
        rider_off = 1'b1;
        ticks(5);
        expect_out("on_rider_only", 2, 1, 255, 0);
        rider_off = 1'b0;
        send_byte(A, 2, "on_unknown");
        send_byte(S, 3, "on_stop");
        expect_out("sp_full", 3, 1, 255, 0);
        send_byte(S, 3, "sp_stop_ignored");
        send_byte(G, 2, "sp_go_full");
        expect_out("sp_back_on", 2, 1, 255, 0);
        rider_off = 1'b1;
        send_byte(S, 0, "t6_stop_rider");
        rider_off = 1'b0;
        expect_out("t6_off", 0, 0, 0, 0);

        // Single-cycle vectors from OFF
        for (int i = 0; i < 10; i++) begin
            rx_rdy       = vecs[i].rdy;
            rx_data      = vecs[i].data;
            rider_off    = vecs[i].rider;
            ovr_i_shtdwn = vecs[i].ovr;
            batt_low     = vecs[i].batt;
            tick();
            expect_out($sformatf("vec%0d", i), vecs[i].st, vecs[i].pwr, vecs[i].sc, vecs[i].flt);
            chk($sformatf("vec%0d_clr", i), int'(clr_rx_rdy), vecs[i].clr);
            $display("[TB] t=%0t vec%0d rdy=%0b data=%02h state=%0d", $time, i,
                     vecs[i].rdy, vecs[i].data, state_o);
        end
        rx_rdy       = 1'b0;
        rider_off    = 1'b0;
        ovr_i_shtdwn = 1'b0;
        batt_low     = 1'b0;

        // Recovery after saturation, with ignored events during the ramp
        ticks(4100);
        batt_low = 1'b1;
        send_byte(G, 4, "t5_fault_batt");
        batt_low = 1'b0;
        send_byte(G, 1, "t7_go");
        expect_out("t7_ramp", 1, 1, 0, 0);
        rider_off = 1'b1;
        ticks(3);
        rider_off = 1'b0;
        chk("t7_rider_in_ramp", int'(state_o), 1);
        send_byte(G, 1, "ramp_g");
        send_byte(A, 1, "ramp_unknown");
        ticks(16311);
        expect_out("t7_k16319", 1, 1, 254, 0);
        tick();
        expect_out("t7_on", 2, 1, 255, 0);

        // Stop pending then rider leaves
        send_byte(S, 3, "t2_stop");
        expect_out("t2_pend", 3, 1, 255, 0);
        rider_off = 1'b1;
        tick();
        expect_out("t2_off", 0, 0, 0, 0);
        rider_off = 1'b0;

        // Asynchronous reset mid-ramp
        send_byte(G, 1, "rst_go");
        ticks(100);
        chk("rst_mid_scale", int'(trq_scale), 1);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("async_rst", 0, 0, 0, 0);
        chk("async_rst_clr", int'(clr_rx_rdy), 0);
        #3;
        rst_n = 1'b1;
        tick();
        expect_out("after_rst", 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
